// File: rtl/nrzi_decode_ap_if.sv
// Receive-side line/decoded-bit bundle between the sampler, the NRZI decoder and the PID logic.
// The master drives the sampled line; the slave (decoder) returns decoded bits and status.
interface nrzi_decode_ap_if;
  logic rx_data_in;
  logic rx_data_valid;
  logic rx_data_out;
  logic rx_bit_valid;
  logic rx_active;
  logic sync_det;
  logic stuff_err;

  modport master (
    output rx_data_in,
    output rx_data_valid,
    input  rx_data_out,
    input  rx_bit_valid,
    input  rx_active,
    input  sync_det,
    input  stuff_err
  );

  modport slave (
    input  rx_data_in,
    input  rx_data_valid,
    output rx_data_out,
    output rx_bit_valid,
    output rx_active,
    output sync_det,
    output stuff_err
  );
endinterface

// File: rtl/nrzi_decode_ap.sv
// USB full-speed receive path: NRZI decode, SYNC detection and bit unstuffing, one bit per gclk.
// All outputs are registered; a sample's response appears the cycle after it is captured.
module nrzi_decode_ap #(
  parameter int unsigned STUFF_LEN      = 6,
  parameter int unsigned SYNC_MIN_ZEROS = 6
) (
  input logic              gclk,
  input logic              reset,
  nrzi_decode_ap_if.slave  bus
);

  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {StIdle, StHunt, StActive, StError} state_e;

  state_e           state_q, state_d;
  logic             prev_level_q, prev_level_d;
  logic [2:0]       zero_cnt_q, zero_cnt_d;
  logic [OnesW-1:0] ones_cnt_q, ones_cnt_d;
  logic             data_out_q, data_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             active_q, active_d;
  logic             sync_q, sync_d;
  logic             err_q, err_d;
  logic             dbit;

  // Unchanged line level decodes to 1, a transition to 0.
  assign dbit = (bus.rx_data_in == prev_level_q);

  always_comb begin
    state_d      = state_q;
    prev_level_d = bus.rx_data_valid ? bus.rx_data_in : 1'b1;
    zero_cnt_d   = zero_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    data_out_d   = data_out_q;
    bit_valid_d  = 1'b0;
    active_d     = active_q;
    sync_d       = 1'b0;
    err_d        = 1'b0;

    if (!bus.rx_data_valid) begin
      state_d    = StIdle;
      zero_cnt_d = '0;
      ones_cnt_d = '0;
      active_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHunt: begin
          state_d = StHunt;
          if (!dbit) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (32'(zero_cnt_q) >= SYNC_MIN_ZEROS) begin
            state_d    = StActive;
            sync_d     = 1'b1;
            active_d   = 1'b1;
            // The SYNC's closing 1 already counts toward the stuffing run.
            ones_cnt_d = OnesW'(1);
            zero_cnt_d = '0;
          end else begin
            zero_cnt_d = '0;
          end
        end
        StActive: begin
          if (ones_cnt_q < OnesW'(STUFF_LEN)) begin
            data_out_d  = dbit;
            bit_valid_d = 1'b1;
            ones_cnt_d  = dbit ? ones_cnt_q + OnesW'(1) : '0;
          end else if (!dbit) begin
            ones_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            state_d    = StError;
            active_d   = 1'b0;
            ones_cnt_d = '0;
          end
        end
        StError: begin
          // Samples ignored until the line goes idle.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_level_q <= 1'b1;
      zero_cnt_q   <= '0;
      ones_cnt_q   <= '0;
      data_out_q   <= 1'b0;
      bit_valid_q  <= 1'b0;
      active_q     <= 1'b0;
      sync_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_level_q <= prev_level_d;
      zero_cnt_q   <= zero_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      data_out_q   <= data_out_d;
      bit_valid_q  <= bit_valid_d;
      active_q     <= active_d;
      sync_q       <= sync_d;
      err_q        <= err_d;
    end
  end

  assign bus.rx_data_out  = data_out_q;
  assign bus.rx_bit_valid = bit_valid_q;
  assign bus.rx_active    = active_q;
  assign bus.sync_det     = sync_q;
  assign bus.stuff_err    = err_q;

endmodule
